wb_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the in-order pipeline writeback (ALU, LUI/AUIPC, JAL/JALR, LOAD results) and the long-latency multiply/divide unit (MDU).
- MDU results are queued in a small FIFO and drained into idle writeback slots.
- A starvation counter forces a one-cycle pipeline stall, so the MDU head can always retire.
- Sits between the writeback stage and the register file.

---
 rtl/wb_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued MDU results.
// Optional macro WB_ARB_BYPASS_EN sends an MDU result straight to rf_* when the FIFO is empty and the pipeline is idle.
module wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [3:0]  WAIT_LAST = 4'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
  state_t state, state_nx;

  logic [4:0]  q_rd   [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, occ, occ_nx;
  logic [3:0]  wait_cnt, wait_nx;
  logic        pipe_eff, bypass, push, pop, full;
  logic        we_nx, stall_nx;
  logic [4:0]  rd_nx;
  logic [31:0] data_nx;

  assign occ       = wr_ptr - rd_ptr;
  assign full      = (occ == FULL_OCC);
  assign mdu_ready = !full;
  assign pipe_eff  = pipe_we && (pipe_rd != 5'd0) && !pipe_stall;
`ifdef WB_ARB_BYPASS_EN
  assign bypass = (state == IDLE) && mdu_valid && !pipe_eff;
`else
  assign bypass = 1'b0;
`endif
  // x0 results are accepted but never stored; bypassed results skip the FIFO
  assign push = mdu_valid && !full && (mdu_rd != 5'd0) && !bypass;

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    stall_nx = 1'b0;
    pop      = 1'b0;
    we_nx    = 1'b0;
    rd_nx    = rf_rd;
    data_nx  = rf_data;
    unique case (state)
      IDLE: begin
        if (pipe_eff) begin
          we_nx   = 1'b1;
          rd_nx   = pipe_rd;
          data_nx = pipe_data;
        end else if (bypass && (mdu_rd != 5'd0)) begin
          we_nx   = 1'b1;
          rd_nx   = mdu_rd;
          data_nx = mdu_data;
        end
      end
      PEND: begin
        if (pipe_eff) begin
          we_nx   = 1'b1;
          rd_nx   = pipe_rd;
          data_nx = pipe_data;
          wait_nx = wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) stall_nx = 1'b1;
        end else begin
          pop     = 1'b1;
          wait_nx = 4'd0;
        end
      end
      FORCE: begin
        pop     = 1'b1;
        wait_nx = 4'd0;
      end
      default: ;
    endcase
    if (pop) begin
      we_nx   = 1'b1;
      rd_nx   = q_rd[rd_ptr[AW-1:0]];
      data_nx = q_data[rd_ptr[AW-1:0]];
    end
    occ_nx = occ + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);
    if (stall_nx)              state_nx = FORCE;
    else if (occ_nx != '0)     state_nx = PEND;
    else                       state_nx = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wait_cnt   <= 4'd0;
      pipe_stall <= 1'b0;
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_data    <= 32'd0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_nx;
      pipe_stall <= stall_nx;
      rf_we      <= we_nx;
      rf_rd      <= rd_nx;
      rf_data    <= data_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // storage needs no reset: pointers alone define validity
  always_ff @(posedge clock) begin
    if (push) begin
      q_rd[wr_ptr[AW-1:0]]   <= mdu_rd;
      q_data[wr_ptr[AW-1:0]] <= mdu_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed plan steps plus random traffic against a queue-level model.
module tb_wb_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = 5'd0;
  logic [31:0] pipe_data = 32'd0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        mdu_ready, pipe_stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  always #5 clock = ~clock;

  // reference model: pending MDU results as a queue of {rd,data}
  logic [36:0] mq[$];
  int          m_wait;
  bit          m_stall, m_we, m_acc;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    bit pe, byp, acc, nstall;
    logic [36:0] head;
    if (reset) begin
      mq.delete();
      m_wait = 0; m_stall = 0; m_we = 0; m_rd = 0; m_data = 0; m_acc = 0;
      return;
    end
    pe     = pipe_we && (pipe_rd != 0) && !m_stall;
    byp    = BYP && (mq.size() == 0) && mdu_valid && !pe;
    acc    = mdu_valid && (mq.size() < DEPTH);
    nstall = 0;
    m_we   = 0;
    if (m_stall || (mq.size() > 0 && !pe)) begin
      head = mq.pop_front();
      m_we = 1; m_rd = head[36:32]; m_data = head[31:0];
      m_wait = 0;
    end else if (pe) begin
      m_we = 1; m_rd = pipe_rd; m_data = pipe_data;
      if (mq.size() > 0) begin
        if (m_wait == MAX_WAIT - 1) nstall = 1;
        m_wait++;
      end
    end else if (byp && mdu_rd != 0) begin
      m_we = 1; m_rd = mdu_rd; m_data = mdu_data;
    end
    if (acc && !byp && mdu_rd != 0) mq.push_back({mdu_rd, mdu_data});
    m_stall = nstall;
    m_acc   = acc;
  endtask

  // called at a negedge: drive, check ready, advance model, cross posedge, check outputs
  task automatic step(input bit rst, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    reset = rst; pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
    chk("mdu_ready", mdu_ready, 32'(mq.size() < DEPTH));
    model();
    @(negedge clock);
    chk("rf_we", rf_we, m_we);
    chk("pipe_stall", pipe_stall, m_stall);
    if (m_we) begin
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_data", rf_data, m_data);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stream(input int n, input int pw_pct, input int mv_pct);
    bit pw, mv, p_fresh;
    logic [4:0] prd, mrd;
    logic [31:0] pd, md;
    pw = 0; prd = 0; pd = 0; mv = 0; mrd = 0; md = 0; p_fresh = 1;
    for (int i = 0; i < n; i++) begin
      if (p_fresh) begin
        pw = int'($urandom_range(99)) < pw_pct; prd = 5'($urandom_range(31)); pd = $urandom;
      end
      if (!mv || m_acc) begin
        mv = int'($urandom_range(99)) < mv_pct; mrd = 5'($urandom_range(31)); md = $urandom;
      end
      p_fresh = !m_stall;  // a request shown during a stall is shown again
      step(0, pw, prd, pd, mv, mrd, md);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_wait = 0; m_stall = 0; m_we = 0; m_acc = 0; m_rd = 0; m_data = 0;
    @(negedge clock);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_data", rf_data, 0);

    // plain pipeline write
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    chk("p_we", rf_we, 1);
    chk("p_rd", rf_rd, 5);
    chk("p_data", rf_data, 32'hDEADBEEF);
    chk("p_stall", pipe_stall, 0);
    idle();

    // x0 from both sides never writes
    step(0, 1, 0, 32'hAAAA5555, 1, 0, 32'h0BAD0BAD);
    chk("x0_we", rf_we, 0);
    idle();
    chk("x0_we_late", rf_we, 0);

    // MDU result with idle pipeline
    step(0, 0, 0, 0, 1, 7, 32'h12345678);
`ifdef WB_ARB_BYPASS_EN
    chk("mdu7_rd", rf_rd, 7);
    chk("mdu7_data", rf_data, 32'h12345678);
`else
    chk("mdu7_not_yet", rf_we, 0);
    idle();
    chk("mdu7_rd", rf_rd, 7);
    chk("mdu7_data", rf_data, 32'h12345678);
`endif
    idle();

    // starvation: four pipeline grants, forced stall pops MDU, held write retires next
    step(0, 1, 1, 32'h100, 1, 9, 32'h99);
    for (int k = 2; k <= 5; k++) step(0, 1, 5'(k), 32'(k), 0, 0, 0);
    chk("starve_stall", pipe_stall, 1);
    chk("starve_last_pipe", rf_rd, 5);
    step(0, 1, 6, 32'h6, 0, 0, 0);
    chk("force_rd", rf_rd, 9);
    chk("force_stall_clr", pipe_stall, 0);
    step(0, 1, 6, 32'h6, 0, 0, 0);
    chk("held_rd", rf_rd, 6);
    idle();

    // fill the FIFO under a busy pipeline; extra pushes are held
    step(0, 1, 1, 32'h11, 1, 10, 32'hA0);
    step(0, 1, 2, 32'h22, 1, 11, 32'hB0);
    chk("full_ready", mdu_ready, 0);
    stream(16, 100, 100);

    // reset with two entries queued and FORCE pending
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h1, 1, 20, 32'h20);
    step(0, 1, 2, 32'h2, 1, 21, 32'h21);
    step(0, 1, 3, 32'h3, 1, 22, 32'h22);
    step(0, 1, 4, 32'h4, 1, 22, 32'h22);
    step(0, 1, 5, 32'h5, 1, 22, 32'h22);
    chk("force_pending", pipe_stall, 1);
    step(1, 1, 6, 32'h6, 1, 22, 32'h22);
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_stall", pipe_stall, 0);
    chk("rst_mid_ready", mdu_ready, 1);
    for (int i = 0; i < 6; i++) idle();

    // random traffic
    stream(400, 60, 40);
    step(1, 0, 0, 0, 0, 0, 0);
    stream(300, 90, 70);
    stream(200, 30, 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
